demux8_buf: RTL and testbench
=============================

# demux8_buf

Registered 1-to-8 demultiplexer with a valid/ready handshake: one input word is steered to one of eight output lanes by a 3-bit select, and each lane holds its word in a one-entry buffer until that lane's consumer takes it. It is the distribution counterpart of the processor's 8-input selector `mux8`, using the same select encoding, so a `mux8` index maps directly to a `demux8_buf` lane. It sits between a single producer, such as the write-back or forwarding path, and up to eight independent consumers.

## Interface
- `n`, 32, data width of the input and of every lane.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `D`  input  n  input data word.
- `S0`, `S1`, `S2`  input  1 each  lane select; lane index = {S0,S1,S2}, with S0 as the MSB (S0=1,S1=0,S2=0 selects lane 4).
- `in_valid`  input  1  producer has a word on `D` for the lane given by the select.
- `in_ready`  output  1  block can accept the word for the selected lane this cycle.
- `Y0`..`Y7`  output  n each  lane data registers.
- `Y_valid`  output  8  bit i means lane i holds an undelivered word.
- `Y_ready`  input  8  bit i means lane i's consumer accepts the word this cycle.
- `occupancy`  output  4  number of lanes with `Y_valid` set (0..8).

## Operation
- **Select decode.** sel = {S0,S1,S2}, interpreted strictly as a binary value. Only the selected lane can load in a given cycle.
- **Ready.** `in_ready` = !`Y_valid`[sel] || `Y_ready`[sel]. It is combinational, so a lane that is being drained in the same cycle can still accept a new word.
- **Accept.** A word is accepted when `in_valid` && `in_ready`. At that edge, `Ysel` <= `D` and `Y_valid`[sel] <= 1.
- **Drain.** Lane i is drained when `Y_valid`[i] && `Y_ready`[i]. If the lane is not loading in the same cycle, `Y_valid`[i] <= 0 and `Yi` holds its stale value.
- **Load and drain on the same lane, same cycle.** The lane takes the new word and `Y_valid` stays 1. Neither word is lost or duplicated.
- **Load one lane while draining another.** Both updates happen independently in the same cycle.
- **`in_valid`=1 with `in_ready`=0.** Nothing changes. The producer must hold `D` and the select stable until the word is accepted.
- **`Y_ready`[i]=1 with `Y_valid`[i]=0.** No effect.
- **Occupancy.** `occupancy` is registered and updated every edge:
  - +1 on an accept into an empty lane, or into a lane that is not being drained;
  - -1 on a drain with no load into that lane;
  - the net change covers all simultaneous events, so every accept and every drain is counted.
  - The invariant is `occupancy` == popcount(`Y_valid`).
- **Full lanes.** There is no overflow: a full lane without `Y_ready` simply deasserts `in_ready`. Other lanes stay independent, so there is no head-of-line blocking across lanes beyond the producer waiting on its own select.

## Timing
- **Reset values.** While `rst_n`=0: `Y0`..`Y7` = 0, `Y_valid` = 8'h00, `occupancy` = 0. `in_ready` reads 1, since all lanes are empty.
- **Reset mid-operation.** Asserting `rst_n` clears all lanes immediately and asynchronously, and buffered words are discarded. Deassertion must be synchronous to `clk`. The first accept can occur at the first rising edge after release.
- **Latency.** A word accepted at edge k appears on `Ysel` with `Y_valid` high after edge k, which is 1 cycle.
- **Throughput.** One word per cycle into any lane whose consumer holds `Y_ready`=1. Sustained alternating lanes also run at one word per cycle.
- **Combinational paths.** The only ones are `Y_ready`/select to `in_ready`. All other outputs are registered.

## Test plan
1. **Reset state.** Apply reset, release, and check: all `Y` = 0, `Y_valid` = 0, `occupancy` = 0, `in_ready` = 1.
2. **Single word, lane 5.** `D`=32'hDEAD_BEEF, S0,S1,S2 = 1,0,1, `in_valid` for 1 cycle, `Y_ready`=0. Next cycle: `Y5`=DEADBEEF, `Y_valid`=8'h20, `occupancy`=1. Then `Y_ready`[5]=1 for 1 cycle, after which `Y_valid`=0 and `occupancy`=0.
3. **Back-pressure.** Lane 2 is full, `Y_ready`[2]=0, and the producer presents 32'h1234 to lane 2. Check `in_ready`=0 and that `Y2` keeps its old value for 5 cycles. Raise `Y_ready`[2]: `in_ready`=1 the same cycle, and `Y2`=1234 after the next edge.
4. **Same-lane load and drain.** Lane 7 holds A, `Y_ready`[7]=1, and B is presented to lane 7. After the edge: `Y7`=B, `Y_valid`[7]=1, `occupancy` unchanged.
5. **Fill all lanes.** Write 8 words to lanes 0..7 on consecutive cycles with `Y_ready`=0. Check `Y_valid`=8'hFF, `occupancy`=8, and `Yi`=i+1. Then drain lanes 3 and 6 while loading lane 3. Check `occupancy`=7 and `Y_valid`=8'hBF.
6. **Reset mid-operation.** With `Y_valid`=8'hFF, pulse `rst_n` low between clock edges. Check that all outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/demux8_buf_if.sv
// rtl/demux8_buf_if.sv - producer/consumer bus bundle for the 1-to-8 buffered demultiplexer
interface demux8_buf_if #(
    parameter int N = 32
);
    logic [N-1:0] D;
    logic         S0;
    logic         S1;
    logic         S2;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] Y0;
    logic [N-1:0] Y1;
    logic [N-1:0] Y2;
    logic [N-1:0] Y3;
    logic [N-1:0] Y4;
    logic [N-1:0] Y5;
    logic [N-1:0] Y6;
    logic [N-1:0] Y7;
    logic [7:0]   Y_valid;
    logic [7:0]   Y_ready;
    logic [3:0]   occupancy;

    modport slave (
        input  D, S0, S1, S2, in_valid, Y_ready,
        output in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, occupancy
    );

    modport master (
        output D, S0, S1, S2, in_valid, Y_ready,
        input  in_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, occupancy
    );
endinterface

// File: rtl/demux8_buf.sv
// rtl/demux8_buf.sv - registered 1-to-8 demux with a one-entry buffer per lane
module demux8_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    demux8_buf_if.slave  bus
);
    logic [N-1:0] y_q [8];
    logic [7:0]   y_valid_q;
    logic [7:0]   y_valid_d;
    logic [3:0]   occ_q;
    logic [3:0]   occ_d;

    logic [2:0]   sel;
    logic [7:0]   drain;
    logic [7:0]   load;
    logic         ready;
    logic         accept;

    // S0 is the MSB, matching the mux8 select encoding.
    assign sel    = {bus.S0, bus.S1, bus.S2};
    assign drain  = y_valid_q & bus.Y_ready;
    assign ready  = !y_valid_q[sel] || bus.Y_ready[sel];
    assign accept = bus.in_valid && ready;
    assign load   = accept ? (8'b1 << sel) : 8'b0;

    assign y_valid_d = (y_valid_q & ~drain) | load;

    // A load into a lane drained the same cycle is a replacement, not a new entry.
    always_comb begin
        occ_d = occ_q;
        if (accept && !drain[sel]) begin
            occ_d = occ_d + 4'd1;
        end
        for (int i = 0; i < 8; i++) begin
            if (drain[i] && !load[i]) begin
                occ_d = occ_d - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= '0;
            end
            y_valid_q <= 8'h00;
            occ_q     <= 4'd0;
        end else begin
            y_valid_q <= y_valid_d;
            occ_q     <= occ_d;
            if (accept) begin
                y_q[sel] <= bus.D;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.Y0        = y_q[0];
    assign bus.Y1        = y_q[1];
    assign bus.Y2        = y_q[2];
    assign bus.Y3        = y_q[3];
    assign bus.Y4        = y_q[4];
    assign bus.Y5        = y_q[5];
    assign bus.Y6        = y_q[6];
    assign bus.Y7        = y_q[7];
    assign bus.Y_valid   = y_valid_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_demux8_buf.sv
// tb/tb_demux8_buf.sv - directed scoreboard bench for demux8_buf
module tb_demux8_buf;
    logic clk;
    logic rst_n;

    demux8_buf_if #(.N(32)) bus ();

    demux8_buf #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lane;
        logic [31:0] data;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] ey[8];
    logic [7:0]  ev;
    logic [3:0]  eocc;
    int          tests;
    int          fails;

    function automatic logic [31:0] get_y(input int i);
        case (i)
            0: get_y = bus.Y0;
            1: get_y = bus.Y1;
            2: get_y = bus.Y2;
            3: get_y = bus.Y3;
            4: get_y = bus.Y4;
            5: get_y = bus.Y5;
            6: get_y = bus.Y6;
            default: get_y = bus.Y7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Y_valid"}, 64'(bus.Y_valid), 64'(ev));
        chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(eocc));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.Y%0d", tag, i), 64'(get_y(i)), 64'(ey[i]));
        end
    endtask

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        popcnt = 4'd0;
        for (int i = 0; i < 8; i++) popcnt = popcnt + 4'(v[i]);
    endfunction

    // Drive one cycle, predict its effect, compare drained words and the post-edge state.
    task automatic step(input string tag, input bit iv, input logic [2:0] sel,
                        input logic [31:0] d, input logic [7:0] yr);
        logic       exp_rdy;
        logic [7:0] nv;
        bit         found;
        bus.D        = d;
        {bus.S0, bus.S1, bus.S2} = sel;
        bus.in_valid = iv;
        bus.Y_ready  = yr;
        #1;
        exp_rdy = !ev[sel] || yr[sel];
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
        nv = ev;
        for (int i = 0; i < 8; i++) begin
            if (ev[i] && yr[i]) begin
                found = 1'b0;
                for (int k = 0; k < sbq.size(); k++) begin
                    if (!found && sbq[k].lane == 3'(i)) begin
                        found = 1'b1;
                        chk($sformatf("%s.drain%0d", tag, i), 64'(get_y(i)), 64'(sbq[k].data));
                        sbq.delete(k);
                    end
                end
                chk($sformatf("%s.sb_hit%0d", tag, i), 64'(found), 64'(1));
                nv[i] = 1'b0;
            end
        end
        if (iv && exp_rdy) begin
            sbq.push_back('{lane: sel, data: d});
            nv[sel] = 1'b1;
            ey[sel] = d;
        end
        ev   = nv;
        eocc = popcnt(nv);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ey[i] = 32'h0;
        ev   = 8'h00;
        eocc = 4'd0;
        sbq.delete();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        rst_n        = 1'b0;
        bus.D        = 32'h0;
        {bus.S0, bus.S1, bus.S2} = 3'd0;
        bus.in_valid = 1'b0;
        bus.Y_ready  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_hold");
        chk("rst_hold.in_ready", 64'(bus.in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_rel");
        chk("rst_rel.in_ready", 64'(bus.in_ready), 64'(1));

        // Single word to lane 5
        step("t2_load", 1'b1, 3'd5, 32'hDEAD_BEEF, 8'h00);
        chk("t2_yvalid_const", 64'(bus.Y_valid), 64'(8'h20));
        chk("t2_y5_const", 64'(bus.Y5), 64'(32'hDEAD_BEEF));
        step("t2_drain", 1'b0, 3'd0, 32'h0, 8'h20);
        chk("t2_occ_const", 64'(bus.occupancy), 64'(0));

        // Back-pressure on lane 2
        step("t3_fill", 1'b1, 3'd2, 32'h0000_AAAA, 8'h00);
        for (int c = 0; c < 5; c++) begin
            step($sformatf("t3_hold%0d", c), 1'b1, 3'd2, 32'h0000_1234, 8'h00);
        end
        chk("t3_y2_old", 64'(bus.Y2), 64'(32'h0000_AAAA));
        step("t3_release", 1'b1, 3'd2, 32'h0000_1234, 8'h04);
        chk("t3_y2_new", 64'(bus.Y2), 64'(32'h0000_1234));

        // Same-lane load and drain on lane 7
        step("t4_a", 1'b1, 3'd7, 32'hAAAA_0007, 8'h00);
        step("t4_b", 1'b1, 3'd7, 32'hBBBB_0007, 8'h80);
        chk("t4_occ_const", 64'(bus.occupancy), 64'(2));

        step("flush", 1'b0, 3'd0, 32'h0, 8'hFF);

        // Fill all lanes, then drain 3 and 6 while reloading 3
        for (int i = 0; i < 8; i++) begin
            step($sformatf("t5_fill%0d", i), 1'b1, 3'(i), 32'(i + 1), 8'h00);
        end
        chk("t5_full_const", 64'(bus.Y_valid), 64'(8'hFF));
        step("t5_full_blocked", 1'b1, 3'd4, 32'hFFFF_FFFF, 8'h00);
        step("t5_mix", 1'b1, 3'd3, 32'h0000_0033, 8'h48);
        chk("t5_occ_const", 64'(bus.occupancy), 64'(7));
        chk("t5_valid_const", 64'(bus.Y_valid), 64'(8'hBF));

        // Asynchronous reset mid-operation
        step("t6_refill", 1'b1, 3'd6, 32'h0000_0066, 8'h00);
        chk("t6_full_const", 64'(bus.Y_valid), 64'(8'hFF));
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_async.in_ready", 64'(bus.in_ready), 64'(1));
        #1;
        rst_n = 1'b1;
        step("t6_first", 1'b1, 3'd0, 32'hC0DE_0000, 8'h00);
        step("t6_drain", 1'b1, 3'd1, 32'hC0DE_0001, 8'h01);

        bus.in_valid = 1'b0;
        bus.Y_ready  = 8'h00;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
